// File: rtl/rm_ctrl_pkg.sv
// Shared types and defaults for the RM decoupling controller.
package rm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_DECOUPLED = 3'd2,
    ST_RESET_RM  = 3'd3
  } rm_state_t;

  localparam int DEF_QUIET_CYCLES  = 16;
  localparam int DEF_DRAIN_TIMEOUT = 1024;
  localparam int DEF_RST_HOLD      = 8;

  // Wide enough to hold max_val itself so counters can saturate on it.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/rm_quiet_timer.sv
// Drain supervision: quiet counter (idle RM output cycles) and overall drain timeout.
// Both counters run only while start is high; clear restarts the quiet count.
module rm_quiet_timer
  import rm_ctrl_pkg::*;
#(
  parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic done,
  output logic timeout
);

  localparam int QW = cnt_width(QUIET_CYCLES);
  localparam int TW = cnt_width(DRAIN_TIMEOUT);
  localparam logic [QW-1:0] QUIET_MAX   = QW'(QUIET_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(DRAIN_TIMEOUT);

  logic [QW-1:0] quiet_reg, quiet_next;
  logic [TW-1:0] time_reg, time_next;

  always_comb begin
    quiet_next = quiet_reg;
    time_next  = time_reg;
    if (!start) begin
      quiet_next = '0;
      time_next  = '0;
    end else begin
      if (clear) begin
        quiet_next = '0;
      end else if (quiet_reg != QUIET_MAX) begin
        quiet_next = quiet_reg + QW'(1);
      end
      if (time_reg != TIMEOUT_MAX) begin
        time_next = time_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quiet_reg <= '0;
      time_reg  <= '0;
    end else begin
      quiet_reg <= quiet_next;
      time_reg  <= time_next;
    end
  end

  // Flag on the cycle the count reaches its limit so the FSM exits on that edge.
  assign done    = start && (quiet_next == QUIET_MAX);
  assign timeout = start && (time_next == TIMEOUT_MAX);

endmodule

// File: rtl/rm_decouple_ctrl.sv
// Sequences isolation, reset and reconnection of one reconfigurable module on AXI-stream.
// Define RM_BEAT_CNT_EN to build the in_beats/out_beats handshake counters.
module rm_decouple_ctrl
  import rm_ctrl_pkg::*;
#(
  parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int RST_HOLD      = DEF_RST_HOLD,
  parameter int GPIO_W        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_TDATA,
  input  logic              s_TVALID,
  output logic              s_TREADY,
  output logic [31:0]       rm_a_TDATA,
  output logic              rm_a_TVALID,
  input  logic              rm_a_TREADY,
  input  logic [31:0]       rm_b_TDATA,
  input  logic              rm_b_TVALID,
  output logic              rm_b_TREADY,
  output logic [31:0]       m_TDATA,
  output logic              m_TVALID,
  input  logic              m_TREADY,
  input  logic              rm_irq,
  input  logic [GPIO_W-1:0] rm_gpio,
  output logic [GPIO_W-1:0] gpio,
  output logic              rm_rst_n,
  input  logic              pr_req,
  output logic              pr_ack,
  input  logic              pr_done,
  output logic              irq,
  input  logic              irq_clr,
  output logic              drain_err,
  output logic [2:0]        state,
  output logic [31:0]       in_beats,
  output logic [31:0]       out_beats
);

  localparam int HW = cnt_width(RST_HOLD);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  rm_state_t     state_reg;
  logic [HW-1:0] hold_reg;
  logic          rm_rst_n_reg;
  logic          pr_ack_reg;
  logic          irq_reg;
  logic          drain_err_reg;

  logic quiet_done;
  logic drain_timeout;
  logic in_drain;
  logic reset_done;
  logic irq_set;
  logic gpio_en;

  assign in_drain   = (state_reg == ST_DRAIN);
  assign reset_done = (state_reg == ST_RESET_RM) && (hold_reg <= HW'(1));
  assign irq_set    = ((state_reg == ST_ACTIVE) && rm_irq) || reset_done;

  rm_quiet_timer #(
    .QUIET_CYCLES (QUIET_CYCLES),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (in_drain),
    .clear  (rm_b_TVALID),
    .done   (quiet_done),
    .timeout(drain_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_RESET_RM;
      hold_reg      <= HOLD_INIT;
      rm_rst_n_reg  <= 1'b0;
      pr_ack_reg    <= 1'b0;
      irq_reg       <= 1'b0;
      drain_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_ACTIVE: begin
          // Never withdraw a beat the RM has not yet accepted.
          if (pr_req && !(s_TVALID && !rm_a_TREADY)) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A forced exit still waits for any stalled output beat to move.
          if (quiet_done || (drain_timeout && !(rm_b_TVALID && !m_TREADY))) begin
            state_reg    <= ST_DECOUPLED;
            pr_ack_reg   <= 1'b1;
            rm_rst_n_reg <= 1'b0;
            if (!quiet_done) begin
              drain_err_reg <= 1'b1;
            end
          end
        end
        ST_DECOUPLED: begin
          if (pr_done) begin
            state_reg  <= ST_RESET_RM;
            pr_ack_reg <= 1'b0;
            hold_reg   <= HOLD_INIT;
          end
        end
        ST_RESET_RM: begin
          if (reset_done) begin
            state_reg    <= ST_ACTIVE;
            rm_rst_n_reg <= 1'b1;
          end else begin
            hold_reg <= hold_reg - HW'(1);
          end
        end
        default: begin
          state_reg    <= ST_RESET_RM;
          hold_reg     <= HOLD_INIT;
          rm_rst_n_reg <= 1'b0;
          pr_ack_reg   <= 1'b0;
        end
      endcase

      if (irq_set) begin
        irq_reg <= 1'b1;
      end else if (irq_clr) begin
        irq_reg <= 1'b0;
      end
    end
  end

  // Stream gating is purely combinational on the registered state.
  always_comb begin
    rm_a_TDATA  = s_TDATA;
    m_TDATA     = rm_b_TDATA;
    rm_a_TVALID = 1'b0;
    s_TREADY    = 1'b0;
    m_TVALID    = 1'b0;
    rm_b_TREADY = 1'b1;
    case (state_reg)
      ST_ACTIVE: begin
        rm_a_TVALID = s_TVALID;
        s_TREADY    = rm_a_TREADY;
        m_TVALID    = rm_b_TVALID;
        rm_b_TREADY = m_TREADY;
      end
      ST_DRAIN: begin
        m_TVALID    = rm_b_TVALID;
        rm_b_TREADY = m_TREADY;
      end
      default: begin
        rm_b_TREADY = 1'b1;
      end
    endcase
  end

  assign gpio_en = (state_reg == ST_ACTIVE) || (state_reg == ST_DRAIN);

  for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_gpio
    assign gpio[gi] = rm_gpio[gi] & gpio_en;
  end

  assign rm_rst_n  = rm_rst_n_reg;
  assign pr_ack    = pr_ack_reg;
  assign irq       = irq_reg;
  assign drain_err = drain_err_reg;
  assign state     = state_reg;

`ifdef RM_BEAT_CNT_EN
  logic [31:0] in_beats_reg;
  logic [31:0] out_beats_reg;

  // Survive reconfiguration; only a controller reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_beats_reg  <= '0;
      out_beats_reg <= '0;
    end else begin
      if (s_TVALID && s_TREADY) begin
        in_beats_reg <= in_beats_reg + 32'd1;
      end
      if (m_TVALID && m_TREADY) begin
        out_beats_reg <= out_beats_reg + 32'd1;
      end
    end
  end

  assign in_beats  = in_beats_reg;
  assign out_beats = out_beats_reg;
`else
  assign in_beats  = '0;
  assign out_beats = '0;
`endif

endmodule

// File: tb/tb_rm_decouple_ctrl.sv
// Randomized scoreboard bench for rm_decouple_ctrl with a loopback RM model.
module tb_rm_decouple_ctrl;

  localparam int GPIO_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [31:0]       s_TDATA;
  logic              s_TVALID;
  logic              s_TREADY;
  logic [31:0]       rm_a_TDATA;
  logic              rm_a_TVALID;
  logic              rm_a_TREADY;
  logic [31:0]       rm_b_TDATA;
  logic              rm_b_TVALID;
  logic              rm_b_TREADY;
  logic [31:0]       m_TDATA;
  logic              m_TVALID;
  logic              m_TREADY;
  logic              rm_irq;
  logic [GPIO_W-1:0] rm_gpio;
  logic [GPIO_W-1:0] gpio;
  logic              rm_rst_n;
  logic              pr_req;
  logic              pr_ack;
  logic              pr_done;
  logic              irq;
  logic              irq_clr;
  logic              drain_err;
  logic [2:0]        state;
  logic [31:0]       in_beats;
  logic [31:0]       out_beats;

  rm_decouple_ctrl #(
    .QUIET_CYCLES (16),
    .DRAIN_TIMEOUT(1024),
    .RST_HOLD     (8),
    .GPIO_W       (GPIO_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_TDATA    (s_TDATA),
    .s_TVALID   (s_TVALID),
    .s_TREADY   (s_TREADY),
    .rm_a_TDATA (rm_a_TDATA),
    .rm_a_TVALID(rm_a_TVALID),
    .rm_a_TREADY(rm_a_TREADY),
    .rm_b_TDATA (rm_b_TDATA),
    .rm_b_TVALID(rm_b_TVALID),
    .rm_b_TREADY(rm_b_TREADY),
    .m_TDATA    (m_TDATA),
    .m_TVALID   (m_TVALID),
    .m_TREADY   (m_TREADY),
    .rm_irq     (rm_irq),
    .rm_gpio    (rm_gpio),
    .gpio       (gpio),
    .rm_rst_n   (rm_rst_n),
    .pr_req     (pr_req),
    .pr_ack     (pr_ack),
    .pr_done    (pr_done),
    .irq        (irq),
    .irq_clr    (irq_clr),
    .drain_err  (drain_err),
    .state      (state),
    .in_beats   (in_beats),
    .out_beats  (out_beats)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rm_q[$];

  // RM model controls: a_mode 0=random ready, 1=ready low, 2=ready high.
  int a_mode      = 0;
  bit rm_b_hold   = 1'b0;
  bit force_valid = 1'b0;
  bit m_force     = 1'b0;
  bit sb_en       = 1'b1;
  int in_sent     = 0;
  int mon_total   = 0;
  int mon_beats   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit hs;
    hs = 1'b0;
    s_TDATA  = d;
    s_TVALID = 1'b1;
    exp_q.push_back(d);
    in_sent++;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      hs = s_TREADY;
      step();
      if (hs) break;
    end
    s_TVALID = 1'b0;
    chk("send_handshake", 32'(hs), 32'd1);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Loopback RM: accepted rm_a beats reappear on rm_b in order.
  initial begin
    rm_a_TREADY = 1'b0;
    rm_b_TVALID = 1'b0;
    rm_b_TDATA  = '0;
    forever begin
      @(posedge clk);
      #2;
      rm_a_TREADY = (a_mode == 0) ? ($urandom_range(0, 1) != 0) : (a_mode == 2);
      rm_b_TVALID = force_valid || (!rm_b_hold && rm_q.size() > 0);
      rm_b_TDATA  = force_valid ? 32'hDEAD_BEEF : ((rm_q.size() > 0) ? rm_q[0] : 32'h0);
      @(negedge clk);
      if (rm_b_TVALID && rm_b_TREADY && !force_valid && rm_q.size() > 0) begin
        void'(rm_q.pop_front());
      end
      if (rm_a_TVALID === 1'b1 && rm_a_TREADY) begin
        rm_q.push_back(rm_a_TDATA);
      end
    end
  end

  // Output monitor: pops the scoreboard on every downstream handshake.
  initial begin
    logic [31:0] exp_d;
    m_TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_TREADY = m_force ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (rst_n && m_TVALID === 1'b1 && m_TREADY) begin
        mon_total++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%08h, expected no beat", m_TDATA);
          end else begin
            exp_d = exp_q.pop_front();
            chk("m_TDATA", m_TDATA, exp_d);
            $display("beat %0d data=0x%08h", mon_beats, m_TDATA);
            mon_beats++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int qc;
    int dc;
    bit bad;
    logic [GPIO_W-1:0] gv;

    rst_n    = 1'b0;
    s_TDATA  = '0;
    s_TVALID = 1'b0;
    rm_irq   = 1'b0;
    rm_gpio  = 10'h3FF;
    pr_req   = 1'b0;
    pr_done  = 1'b0;
    irq_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd3);
    chk("rst_rm_rst_n", 32'(rm_rst_n), 32'd0);
    chk("rst_pr_ack", 32'(pr_ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_drain_err", 32'(drain_err), 32'd0);
    chk("rst_gpio", 32'(gpio), 32'd0);
    chk("rst_s_TREADY", 32'(s_TREADY), 32'd0);
    chk("rst_m_TVALID", 32'(m_TVALID), 32'd0);
    chk("rst_rm_b_TREADY", 32'(rm_b_TREADY), 32'd1);
    chk("rst_in_beats", in_beats, 32'd0);
    chk("rst_out_beats", out_beats, 32'd0);

    rc = 0;
    for (int i = 0; i < 50; i++) begin
      if (state != 3'd3) break;
      rc++;
      @(negedge clk);
    end
    chk("rst_hold_cycles", 32'(rc), 32'd8);
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_rm_rst_n", 32'(rm_rst_n), 32'd1);
    chk("post_rst_irq", 32'(irq), 32'd1);

    step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_clr", 32'(irq), 32'd0);

    for (int k = 0; k < 3; k++) begin
      step();
      gv = GPIO_W'($urandom());
      rm_gpio = gv;
      @(negedge clk);
      chk("gpio_pass", 32'(gpio), 32'(gv));
    end

    // pr_done outside DECOUPLED is ignored
    step();
    pr_done = 1'b1;
    step();
    pr_done = 1'b0;
    @(negedge clk);
    chk("pr_done_ignored_state", 32'(state), 32'd0);
    chk("pr_done_ignored_rst", 32'(rm_rst_n), 32'd1);

    // Random-gap stream of 100 beats
    step();
    for (int b = 0; b < 100; b++) begin
      repeat ($urandom_range(0, 2)) step();
      send_beat(32'(b));
    end
    wait_empty("stream_all_delivered");
    chk("stream_beat_count", 32'(mon_beats), 32'd100);

    // irq set, set-wins-over-clear, then clear
    rm_irq = 1'b1;
    step();
    rm_irq = 1'b0;
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    step();
    rm_irq  = 1'b1;
    irq_clr = 1'b1;
    step();
    rm_irq  = 1'b0;
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_set_wins", 32'(irq), 32'd1);
    step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);

    // Two beats parked inside the RM, then a stalled beat with pr_req
    step();
    rm_gpio   = 10'h155;
    rm_b_hold = 1'b1;
    a_mode    = 2;
    send_beat(32'hA3);
    send_beat(32'hA4);
    a_mode   = 1;
    s_TDATA  = 32'hA5;
    s_TVALID = 1'b1;
    exp_q.push_back(32'hA5);
    in_sent++;
    pr_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_state", 32'(state), 32'd0);
      chk("stall_rm_a_TVALID", 32'(rm_a_TVALID), 32'd1);
      chk("stall_rm_a_TDATA", rm_a_TDATA, 32'hA5);
      step();
    end
    a_mode = 2;
    @(negedge clk);
    chk("stall_release_ready", 32'(s_TREADY), 32'd1);
    chk("stall_release_state", 32'(state), 32'd0);
    step();
    s_TVALID = 1'b0;
    @(negedge clk);
    chk("drain_entered", 32'(state), 32'd1);
    chk("drain_rm_a_TVALID", 32'(rm_a_TVALID), 32'd0);
    chk("drain_s_TREADY", 32'(s_TREADY), 32'd0);

    // Trailing beats flow out, then the quiet window closes the drain
    step();
    rm_b_hold = 1'b0;
    a_mode    = 0;
    qc        = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state == 3'd2) break;
      if (rm_b_TVALID) qc = 0;
      else qc++;
    end
    chk("drain_quiet_cycles", 32'(qc), 32'd16);
    chk("drain_trailing_delivered", 32'(exp_q.size()), 32'd0);
    chk("decoupled_state", 32'(state), 32'd2);
    chk("decoupled_pr_ack", 32'(pr_ack), 32'd1);
    chk("decoupled_drain_err", 32'(drain_err), 32'd0);
    chk("decoupled_rm_rst_n", 32'(rm_rst_n), 32'd0);
    chk("decoupled_gpio", 32'(gpio), 32'd0);
    chk("decoupled_m_TVALID", 32'(m_TVALID), 32'd0);
    chk("decoupled_rm_b_TREADY", 32'(rm_b_TREADY), 32'd1);

    step();
    pr_req = 1'b0;
    rm_irq = 1'b1;
    step();
    rm_irq = 1'b0;
    @(negedge clk);
    chk("decoupled_irq_ignored", 32'(irq), 32'd0);
    chk("decoupled_holds", 32'(state), 32'd2);

    // Bitstream loaded: RST_HOLD cycles of reset, then reconnect
    step();
    pr_done = 1'b1;
    step();
    pr_done = 1'b0;
    rc  = 0;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state != 3'd3) break;
      rc++;
      bad = bad | pr_ack | rm_rst_n;
    end
    chk("reconf_hold_cycles", 32'(rc), 32'd8);
    chk("reconf_ack_rst_low", 32'(bad), 32'd0);
    chk("reconf_state", 32'(state), 32'd0);
    chk("reconf_rm_rst_n", 32'(rm_rst_n), 32'd1);
    chk("reconf_irq", 32'(irq), 32'd1);
`ifdef RM_BEAT_CNT_EN
    chk("reconf_in_beats", in_beats, 32'(in_sent));
    chk("reconf_out_beats", out_beats, 32'(mon_total));
`else
    chk("reconf_in_beats_off", in_beats, 32'd0);
    chk("reconf_out_beats_off", out_beats, 32'd0);
`endif

    // RM never goes idle: forced decouple at the drain timeout
    step();
    irq_clr = 1'b1;
    step();
    irq_clr     = 1'b0;
    sb_en       = 1'b0;
    force_valid = 1'b1;
    m_force     = 1'b1;
    pr_req      = 1'b1;
    dc          = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (state == 3'd2) break;
      if (state == 3'd1) dc++;
    end
    chk("timeout_drain_cycles", 32'(dc), 32'd1024);
    chk("timeout_state", 32'(state), 32'd2);
    chk("timeout_drain_err", 32'(drain_err), 32'd1);
    chk("timeout_pr_ack", 32'(pr_ack), 32'd1);

    step();
    pr_req      = 1'b0;
    force_valid = 1'b0;
    m_force     = 1'b0;
    pr_done     = 1'b1;
    step();
    pr_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state == 3'd0) break;
    end
    chk("timeout_reconf_state", 32'(state), 32'd0);
    chk("drain_err_sticky", 32'(drain_err), 32'd1);
    chk("timeout_reconf_irq", 32'(irq), 32'd1);
`ifdef RM_BEAT_CNT_EN
    chk("final_out_beats", out_beats, 32'(mon_total));
`endif

    // Reconnected RM carries traffic again
    step();
    sb_en = 1'b1;
    for (int b = 0; b < 5; b++) begin
      send_beat(32'h200 + 32'(b));
    end
    wait_empty("post_reconf_delivered");
    chk("post_reconf_beat_count", 32'(mon_beats), 32'd108);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rm_decouple_ctrl.md
Name: rm_decouple_ctrl

Overview:
- Sequencing controller between the static AXI-stream fabric and one partially reconfigurable module (RM).
- RM interface: 32-bit stream in (a), 32-bit stream out (b), irq, 10-bit gpio.
- On a reconfiguration request it closes the input at a beat boundary, drains the output, decouples and holds the RM in reset, and acknowledges. After the bitstream is loaded it releases reset and reconnects the RM.
- Also latches the RM irq into a sticky, clearable interrupt.

Parameters:
- QUIET_CYCLES, 16: consecutive idle output cycles that declare the RM drained.
- DRAIN_TIMEOUT, 1024: maximum cycles spent in DRAIN before a forced decouple.
- RST_HOLD, 8: cycles rm_rst_n is held low after pr_done.
- GPIO_W, 10: gpio width.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  synchronous active-low reset
- s_TDATA  in  32  upstream data
- s_TVALID  in  1  upstream valid
- s_TREADY  out  1  upstream ready
- rm_a_TDATA  out  32  data to RM
- rm_a_TVALID  out  1  valid to RM
- rm_a_TREADY  in  1  ready from RM
- rm_b_TDATA  in  32  data from RM
- rm_b_TVALID  in  1  valid from RM
- rm_b_TREADY  out  1  ready to RM
- m_TDATA  out  32  downstream data
- m_TVALID  out  1  downstream valid
- m_TREADY  in  1  downstream ready
- rm_irq  in  1  RM interrupt, level
- rm_gpio  in  GPIO_W  gpio from RM
- gpio  out  GPIO_W  gated gpio
- rm_rst_n  out  1  RM reset, active low
- pr_req  in  1  reconfiguration request, level, held until pr_ack
- pr_ack  out  1  RM isolated, safe to reconfigure
- pr_done  in  1  one-cycle pulse, bitstream loaded
- irq  out  1  sticky interrupt
- irq_clr  in  1  clears irq
- drain_err  out  1  sticky, drain timed out
- state  out  3  current FSM state encoding
- in_beats  out  32  optional beat counter (see Optional Feature)
- out_beats  out  32  optional beat counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=RESET_RM with hold counter loaded to RST_HOLD.
  - rm_rst_n=0, pr_ack=0, irq=0, drain_err=0, gpio=0, counters=0.
  - The stream outputs follow the RESET_RM gating. A reset mid-operation aborts any state the same way.
- FSM states and encodings:
  - ACTIVE, 0: transparent pass-through; rm_a_*=s_*, s_TREADY=rm_a_TREADY, m_*=rm_b_*, rm_b_TREADY=m_TREADY, gpio=rm_gpio.
    - Leaves to DRAIN when pr_req=1 and no stalled input beat, i.e. !(s_TVALID && !rm_a_TREADY).
    - A stalled beat delays the transition until its handshake completes, so rm_a_TVALID never drops before its handshake.
  - DRAIN, 1: s_TREADY=0, rm_a_TVALID=0; output path still transparent.
    - Quiet counter increments on cycles with rm_b_TVALID=0 and resets on any rm_b_TVALID=1.
    - Exits to DECOUPLED when the count reaches QUIET_CYCLES.
    - Timeout counter increments every cycle. At DRAIN_TIMEOUT, if !(rm_b_TVALID && !m_TREADY), it sets drain_err and forces DECOUPLED. Otherwise it waits for that condition.
  - DECOUPLED, 2: s_TREADY=0, rm_a_TVALID=0, m_TVALID=0, rm_b_TREADY=1 (discard), gpio=0, rm_rst_n=0, pr_ack=1.
    - pr_done=1 moves to RESET_RM. pr_done outside DECOUPLED is ignored.
  - RESET_RM, 3: same gating as DECOUPLED, but pr_ack=0.
    - rm_rst_n=0 for exactly RST_HOLD cycles, then ACTIVE.
    - rm_rst_n rises on the same edge that enters ACTIVE.
- pr_req deasserting during DRAIN: complete the drain anyway; no abort path.
- Latency: the stream path is combinational, 0 cycles. State changes take effect at the next clk edge.
- Interrupts:
  - irq is set on any cycle with rm_irq=1 in ACTIVE, and also on the cycle RESET_RM→ACTIVE (reconfiguration complete).
  - irq_clr clears irq. A simultaneous set and irq_clr leaves irq=1 (set wins).
  - rm_irq outside ACTIVE is ignored.
- drain_err: cleared only by reset.
- Counter widths: clog2(max parameter)+1 bits, saturating; no wrap.

Optional Feature:
- Macro: RM_BEAT_CNT_EN.
- Defined: in_beats increments on every s_TVALID&&s_TREADY and out_beats on every m_TVALID&&m_TREADY. Both are 32-bit, wrap modulo 2^32, cleared by reset only, and not cleared on reconfiguration.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package rm_ctrl_pkg holds:
  - state enum with the encodings above
  - default constants for QUIET_CYCLES, DRAIN_TIMEOUT, RST_HOLD
  - a function computing counter width
- One sub-module, rm_quiet_timer: quiet counter plus timeout counter, with start/clear inputs and done/timeout outputs.

Test Plan:
- Reset then idle: after 8 cycles state=0 and rm_rst_n=1. The RST_HOLD=8 cycles of rm_rst_n=0 produce an irq=1 pulse latch; irq_clr → irq=0.
- Stream 100 beats 0x0..0x63 with random m_TREADY → m_TDATA sequence identical, in order, none lost.
- pr_req while beat 0xA5 is stalled (rm_a_TREADY=0 for 5 cycles) → state stays 0 until the handshake, then 1. rm_a_TVALID never drops before the handshake.
- DRAIN with RM emitting 3 trailing beats → all 3 reach m_*. Then 16 quiet cycles → state=2, pr_ack=1, drain_err=0.
- RM holding rm_b_TVALID=1 continuously with m_TREADY=1 → at cycle 1024 of DRAIN, drain_err=1 and state=2.
- In DECOUPLED, pulse pr_done → pr_ack=0, rm_rst_n=0 for 8 cycles, then state=0 and irq=1. With RM_BEAT_CNT_EN, the beat counts are preserved across reconfiguration.
